// File: rtl/harness.sv
// Timestamping real-time clock: 48-bit seconds plus 32.26 fixed-point nanoseconds.
// Provides a register port, a generated PPS output and PPS-input time capture.
module harness #(
    parameter int unsigned PPS_WIDTH_NS = 10_000_000,
    parameter int unsigned NS_PER_SEC   = 1_000_000_000,
    parameter logic [31:0] TICK_INC_RST = 32'h1999_999A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  reg_addr,
    input  logic        reg_wr,
    input  logic [31:0] reg_wdata,
    input  logic        reg_rd,
    output logic [31:0] reg_rdata,
    input  logic        pps_i,
    output logic        pps_o,
    output logic [79:0] rtc_std,
    output logic [79:0] pts_std
);

    typedef enum logic [7:0] {
        ADDR_SC_OFST0 = 8'h00,
        ADDR_SC_OFST1 = 8'h04,
        ADDR_NS_OFST  = 8'h08,
        ADDR_RTC_CTL  = 8'h0C,
        ADDR_TICK_INC = 8'h10,
        ADDR_PTS_SECH = 8'h14,
        ADDR_PTS_SECL = 8'h18,
        ADDR_PTS_NS   = 8'h1C,
        ADDR_RTC_SECH = 8'h20,
        ADDR_RTC_SECL = 8'h24,
        ADDR_RTC_NS   = 8'h28
    } reg_addr_e;

    localparam logic [31:0] LP_NS_PER_SEC = 32'(NS_PER_SEC);
    localparam logic [31:0] LP_PPS_WIDTH  = 32'(PPS_WIDTH_NS);

    // Configuration registers
    logic [15:0] r_sc_ofst0;
    logic [31:0] r_sc_ofst1;
    logic [31:0] r_ns_ofst;
    logic [31:0] r_tick_inc;

    // Time counter
    logic [47:0] r_sec;
    logic [31:0] r_ns;
    logic [25:0] r_frac;

    logic [79:0] r_pts;
    logic [79:0] r_snap;
    logic [31:0] r_rdata;
    logic        r_pps_o;
    logic        r_pps_meta;
    logic        r_pps_sync;
    logic        r_pps_prev;

    logic        w_ctl_wr;
    logic        w_clear;
    logic        w_load;
    logic [57:0] w_sum;
    logic [31:0] w_ns_raw;
    logic        w_roll;
    logic [31:0] w_ns_next;
    logic [47:0] w_sec_next;
    logic [31:0] w_rd_data;
    logic        w_pps_rise;

    // RTC_CTL is a pure strobe: decoded straight from the write so load/clear land
    // on the write edge and nothing is left pending for a reset to abort.
    assign w_ctl_wr = reg_wr && (reg_addr == ADDR_RTC_CTL);
    assign w_clear  = w_ctl_wr && reg_wdata[1];
    assign w_load   = w_ctl_wr && reg_wdata[0] && !reg_wdata[1];

    assign w_sum      = {r_ns, r_frac} + {26'b0, r_tick_inc};
    assign w_ns_raw   = w_sum[57:26];
    assign w_roll     = (w_ns_raw >= LP_NS_PER_SEC);
    assign w_ns_next  = w_roll ? (w_ns_raw - LP_NS_PER_SEC) : w_ns_raw;
    assign w_sec_next = w_roll ? (r_sec + 48'd1) : r_sec;

    assign w_pps_rise = r_pps_sync && !r_pps_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sc_ofst0 <= '0;
            r_sc_ofst1 <= '0;
            r_ns_ofst  <= '0;
            r_tick_inc <= TICK_INC_RST;
        end else if (reg_wr) begin
            case (reg_addr)
                ADDR_SC_OFST0: r_sc_ofst0 <= reg_wdata[15:0];
                ADDR_SC_OFST1: r_sc_ofst1 <= reg_wdata;
                ADDR_NS_OFST:  r_ns_ofst  <= reg_wdata;
                ADDR_TICK_INC: r_tick_inc <= reg_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec  <= '0;
            r_ns   <= '0;
            r_frac <= '0;
        end else if (w_clear) begin
            r_sec  <= '0;
            r_ns   <= '0;
            r_frac <= '0;
        end else if (w_load) begin
            r_sec  <= {r_sc_ofst0, r_sc_ofst1};
            r_ns   <= r_ns_ofst;
            r_frac <= '0;
        end else begin
            r_sec  <= w_sec_next;
            r_ns   <= w_ns_next;
            r_frac <= w_sum[25:0];
        end
    end

    // PPS output follows the published time, one clock behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pps_o <= 1'b0;
        end else begin
            r_pps_o <= (r_ns < LP_PPS_WIDTH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pps_meta <= 1'b0;
            r_pps_sync <= 1'b0;
            r_pps_prev <= 1'b0;
            r_pts      <= '0;
        end else begin
            r_pps_meta <= pps_i;
            r_pps_sync <= r_pps_meta;
            r_pps_prev <= r_pps_sync;
            if (w_pps_rise) begin
                r_pts <= {r_sec, r_ns};
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_rd_data = '0;
        case (reg_addr)
            ADDR_SC_OFST0: w_rd_data = {16'b0, r_sc_ofst0};
            ADDR_SC_OFST1: w_rd_data = r_sc_ofst1;
            ADDR_NS_OFST:  w_rd_data = r_ns_ofst;
            ADDR_TICK_INC: w_rd_data = r_tick_inc;
            ADDR_PTS_SECH: w_rd_data = {16'b0, r_pts[79:64]};
            ADDR_PTS_SECL: w_rd_data = r_pts[63:32];
            ADDR_PTS_NS:   w_rd_data = r_pts[31:0];
            ADDR_RTC_SECH: w_rd_data = {16'b0, r_sec[47:32]};
            ADDR_RTC_SECL: w_rd_data = r_snap[63:32];
            ADDR_RTC_NS:   w_rd_data = r_snap[31:0];
            default:       w_rd_data = '0;
        endcase
    end

    // Reading sec-high freezes the full time so the low words match it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_snap  <= '0;
        end else if (reg_rd) begin
            r_rdata <= w_rd_data;
            if (reg_addr == ADDR_RTC_SECH) begin
                r_snap <= {r_sec, r_ns};
            end
        end
    end

    assign reg_rdata = r_rdata;
    assign pps_o     = r_pps_o;
    assign rtc_std   = {r_sec, r_ns};
    assign pts_std   = r_pts;

endmodule

// File: tb/tb_harness.sv
// Directed bench for harness: register access, load/clear, rollover, PPS out/in, coherent read, reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_harness;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  reg_addr;
    logic        reg_wr;
    logic [31:0] reg_wdata;
    logic        reg_rd;
    logic [31:0] reg_rdata;
    logic        pps_o;
    logic [79:0] rtc_std;
    logic [79:0] pts_std;
    logic        pps_tie;
    logic        pps_man;
    wire         pps_i = pps_tie ? pps_o : pps_man;

    int n_vec  = 0;
    int n_miss = 0;

    harness dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reg_addr  (reg_addr),
        .reg_wr    (reg_wr),
        .reg_wdata (reg_wdata),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .pps_i     (pps_i),
        .pps_o     (pps_o),
        .rtc_std   (rtc_std),
        .pts_std   (pts_std)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check(tag, {48'b0, obs}, {48'b0, exp});
    endtask

    // Called at a falling edge; returns at the falling edge after the write was sampled.
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        reg_wr    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        @(negedge clk);
        reg_wr    = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        reg_rd   = 1'b1;
        reg_addr = a;
        @(negedge clk);
        reg_rd   = 1'b0;
        d        = reg_rdata;
    endtask

    task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        check32(tag, d, exp);
    endtask

    initial begin
        logic        prev;
        int          rises;
        int          first_rise;
        int          highs;

        rst_n = 1'b0; reg_addr = '0; reg_wr = 1'b0; reg_wdata = '0; reg_rd = 1'b0;
        pps_tie = 1'b0; pps_man = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_rtc", rtc_std, 80'h0);
        check("rst_pts", pts_std, 80'h0);
        check32("rst_pps", {31'b0, pps_o}, 32'd0);
        check32("rst_rdata", reg_rdata, 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        check("first_tick", rtc_std, {48'h0, 32'd6});
        rd_check("tick_inc_rst", 8'h10, 32'h1999_999A);

        // Load and count
        wr(8'h00, 32'h11);
        wr(8'h04, 32'h1234_5678);
        wr(8'h08, 32'h0150_0000);
        wr(8'h0C, 32'h1);
        check("load", rtc_std, 80'h0011_1234_5678_0150_0000);
        @(negedge clk);
        check("load_tick1", rtc_std, 80'h0011_1234_5678_0150_0006);
        repeat (4) @(negedge clk);
        check("load_tick5", rtc_std, 80'h0011_1234_5678_0150_0020);
        rd_check("rb_sc0", 8'h00, 32'h11);
        rd_check("rb_sc1", 8'h04, 32'h1234_5678);
        rd_check("rb_ns", 8'h08, 32'h0150_0000);
        rd_check("rb_ctl", 8'h0C, 32'h0);

        // Clear, then clear+load together
        wr(8'h0C, 32'h2);
        check("clear", rtc_std, 80'h0);
        @(negedge clk);
        check("clear_tick", rtc_std, {48'h0, 32'd6});
        wr(8'h0C, 32'h3);
        check("clear_wins", rtc_std, 80'h0);
        @(negedge clk);
        check("clear_wins_tick", rtc_std, {48'h0, 32'd6});

        // Zero increment freezes the counter
        wr(8'h10, 32'h0);
        rd_check("rb_tick0", 8'h10, 32'h0);
        wr(8'h0C, 32'h1);
        repeat (10) @(negedge clk);
        check("frozen", rtc_std, 80'h0011_1234_5678_0150_0000);

        // Seconds wrap at 2^48-1 and PPS output latency
        wr(8'h10, 32'h1999_999A);
        wr(8'h00, 32'hFFFF);
        wr(8'h04, 32'hFFFF_FFFF);
        wr(8'h08, 32'd999_999_990);
        wr(8'h0C, 32'h1);
        check("wrap_load", rtc_std, {48'hFFFF_FFFF_FFFF, 32'd999_999_990});
        @(negedge clk);
        check("wrap_tick1", rtc_std, {48'hFFFF_FFFF_FFFF, 32'd999_999_996});
        @(negedge clk);
        check("wrap_tick2", rtc_std, {48'h0, 32'd2});
        check32("wrap_pps_lat", {31'b0, pps_o}, 32'd0);
        @(negedge clk);
        check32("wrap_pps_on", {31'b0, pps_o}, 32'd1);
        check("wrap_tick3", rtc_std, {48'h0, 32'd9});

        // Oversized loaded ns corrected on the next tick
        wr(8'h00, 32'h0);
        wr(8'h04, 32'h5);
        wr(8'h08, 32'd1_000_000_005);
        wr(8'h0C, 32'h1);
        @(negedge clk);
        check("ns_fixup", rtc_std, {48'h6, 32'd11});

        // Second rollover, one PPS rise, pps_i tied to pps_o captures the time
        wr(8'h00, 32'h11);
        wr(8'h04, 32'h2222_3333);
        wr(8'h08, 32'd999_999_000);
        wr(8'h0C, 32'h1);
        prev = 1'b1; rises = 0; first_rise = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (pps_o && !prev) begin
                rises++;
                if (first_rise == 0) first_rise = k;
            end
            prev = pps_o;
            if (k == 2) pps_tie = 1'b1;
        end
        check32("pps_rises", 32'(rises), 32'd1);
        check32("pps_rise_at", 32'(first_rise), 32'd158);
        check("roll_sec", {32'b0, rtc_std[79:32]}, {32'b0, 48'h11_2222_3334});
        check("pts_capture", pts_std, {48'h11_2222_3334, 32'd24});
        pps_tie = 1'b0;
        rd_check("pts_sech", 8'h14, 32'h11);
        rd_check("pts_secl", 8'h18, 32'h2222_3334);
        rd_check("pts_ns", 8'h1C, 32'd24);

        // PPS high time: starting 1000 ns below the width
        wr(8'h08, 32'd9_999_000);
        wr(8'h0C, 32'h1);
        highs = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (pps_o) highs++;
        end
        check32("pps_high_clks", 32'(highs), 32'd157);

        // Coherent read of the running time
        wr(8'h00, 32'hABCD);
        wr(8'h04, 32'h1);
        wr(8'h08, 32'h100);
        wr(8'h0C, 32'h1);
        rd_check("rtc_sech", 8'h20, 32'hABCD);
        rd_check("rtc_secl", 8'h24, 32'h1);
        rd_check("rtc_ns", 8'h28, 32'h100);
        rd_check("rtc_secl_again", 8'h24, 32'h1);

        // Unmapped and read-only addresses
        rd_check("unmapped", 8'h30, 32'h0);
        wr(8'h14, 32'hDEAD_BEEF);
        rd_check("ro_ignored", 8'h14, 32'h11);
        wr(8'h2C, 32'hDEAD_BEEF);
        rd_check("unmapped_wr", 8'h2C, 32'h0);

        // Asynchronous reset mid-run
        #2 rst_n = 1'b0;
        #1;
        check("midrst_rtc", rtc_std, 80'h0);
        check("midrst_pts", pts_std, 80'h0);
        check32("midrst_rdata", reg_rdata, 32'd0);
        check32("midrst_pps", {31'b0, pps_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_resume", rtc_std, {48'h0, 32'd6});
        rd_check("midrst_tick", 8'h10, 32'h1999_999A);
        rd_check("midrst_sc1", 8'h04, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/harness.md
HARNESS -- requirements
Module: harness

Interface
REQ-001 Parameter PPS_WIDTH_NS, default 10_000_000, pps_o high time in ns (10 ms).
REQ-002 Parameter NS_PER_SEC, default 1_000_000_000, ns rollover value.
REQ-003 Parameter TICK_INC_RST, default 32'h1999_999A, tick_inc reset value (6.4 ns).
REQ-004 Port clk, input, 1, single system clock (156.25 MHz nominal); all logic in this domain.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port reg_addr, input, 8, register word address.
REQ-007 Port reg_wr, input, 1, one-cycle write strobe.
REQ-008 Port reg_wdata, input, 32, write data.
REQ-009 Port reg_rd, input, 1, one-cycle read strobe.
REQ-010 Port reg_rdata, output, 32, read data, valid the cycle after reg_rd.
REQ-011 Port pps_i, input, 1, asynchronous external PPS to timestamp.
REQ-012 Port pps_o, output, 1, generated pulse-per-second.
REQ-013 Port rtc_std, output, 80, current time {sec[47:0], ns[31:0]}.
REQ-014 Port pts_std, output, 80, time captured at last pps_i rising edge.

Function
REQ-015 Register map: 0x00 SC_OFST0 (bits[15:0] = sec[47:32]), 0x04 SC_OFST1 (sec[31:0]), 0x08 NS_OFST (ns), 0x0C RTC_CTL, 0x10 TICK_INC, 0x14/0x18/0x1C read-only pts sec-high/sec-low/ns, 0x20/0x24/0x28 read-only rtc sec-high/sec-low/ns; all R/W registers read back; unmapped reads return 0; writes to read-only/unmapped ignored.
REQ-016 RTC_CTL write: bit0 = load {SC_OFST0[15:0], SC_OFST1, NS_OFST} into counters, fractional accumulator zeroed; bit1 = clear sec, ns, fraction to 0; both self-clearing, read as 0, take effect in the cycle after the write.
REQ-017 bit0 and bit1 set together: clear wins.
REQ-018 TICK_INC is unsigned 6.26 fixed point ns; every clk with no load/clear, {ns, frac[25:0]} += {26'b0, TICK_INC} (58-bit sum).
REQ-019 When the new integer ns >= NS_PER_SEC, subtract NS_PER_SEC (fraction kept) and increment sec in the same cycle.
REQ-020 sec is 48-bit and wraps 2^48-1 -> 0.
REQ-021 Loaded NS_OFST >= NS_PER_SEC is corrected by the rollover rule on the next tick.
REQ-022 A TICK_INC write takes effect on the next increment; value 0 freezes the counter.
REQ-023 rtc_std is registered and reflects the counter after each update.
REQ-024 pps_o is registered, 1 while rtc_std ns < PPS_WIDTH_NS, else 0; rising edge aligns with the second rollover (1-clk latency).
REQ-025 pps_i passes a 2-flop synchronizer; on a synchronized rising edge, pts_std <= rtc_std of that cycle; pts_std holds until the next edge.
REQ-026 Reading rtc sec-high (0x20) snapshots full rtc_std; subsequent 0x24/0x28 reads return the snapshot (coherent read).

Reset
REQ-027 On rst_n low: sec, ns, frac, pts_std, rtc_std, snapshot, SC_OFST0/1, NS_OFST, RTC_CTL = 0, TICK_INC = TICK_INC_RST, pps_o = 0, reg_rdata = 0, synchronizer flops = 0.
REQ-028 Reset mid-operation aborts any pending load/clear; counting resumes from 0 after rst_n release.

Verification
REQ-029 Write SC_OFST0=0x11, SC_OFST1=0x1234_5678, NS_OFST=0x0150_0000, RTC_CTL=1 -> rtc_std = 0x0011_1234_5678_0150_0000 next cycle, then ns advancing 6.4 ns/clk.
REQ-030 After REQ-029, RTC_CTL=2 -> rtc_std = 0 next cycle, then counts from 0.
REQ-031 Load sec 0x11_2222_3333, ns 0, TICK_INC 0x1999_999A, run 1.2 s -> sec = 0x11_2222_3334 at ns rollover, exactly one pps_o rising edge, pps_o high 10 ms.
REQ-032 Tie pps_i = pps_o -> pts_std sec = current sec, pts_std ns < 30 (3-4 clk latency).
REQ-033 Load ns = 999_999_990, sec = 0xFFFF_FFFF_FFFF -> after 2 clk sec = 0, ns in 2..3.
REQ-034 RTC_CTL = 3 -> counters cleared, not loaded; TICK_INC = 0 -> rtc_std constant.
